alu_issue_ctrl: RTL and testbench

//  Issue/writeback sequencer that drives the ALU: accepts one 16-bit instruction per handshake and

---
 rtl/alu_issue_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Issue/writeback sequencer for a 16-bit ALU. Accepts one
//                instruction per handshake, reads both operands from a
//                synchronous register file, presents them and an encoded
//                control word to the ALU, latches the result and flags, then
//                writes back and updates the PSR according to the
//                instruction class. Fixed latency of 4 cycles per
//                instruction (IDLE -> RD -> EX -> WB).
//
//  Ports
//    clk, reset_n               clock (rising edge), async active-low reset
//    instr_valid/instr/instr_ready
//                               instruction handshake (ready only in IDLE)
//    rf_raddr_a/rf_raddr_b      RF read addresses (Rdest / Rsrc from IR)
//    rf_rdata_a/rf_rdata_b      RF read data, valid one cycle after address
//    alu_in1/alu_in2            pass-through of RF read data to the ALU
//    alu_control                encoded ALU control word
//    alu_out/alu_flags          ALU result and {Z,C,F,N,L} flags
//    rf_we/rf_waddr/rf_wdata    RF write port (rf_we is a one-cycle strobe)
//    psr                        processor status register
//    done/illegal               one-cycle pulses in WB
//
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] rf_raddr_a,
    output logic [ADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [15:0]       alu_control,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [FLAG_W-1:0] psr,
    output logic              done,
    output logic              illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_EX   = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [15:0]        ir_q,    ir_d;
    logic [DATA_W-1:0]  res_q,   res_d;
    logic [FLAG_W-1:0]  flg_q,   flg_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [FLAG_W-1:0]  psr_q,   psr_d;

    // ------------------------------------------------------------------
    // Instruction decode (purely from the IR, valid in every state)
    // ------------------------------------------------------------------
    logic [3:0]  w_opcode;
    logic [3:0]  w_func;
    logic        w_is_rform;
    logic        w_cls_write;
    logic        w_cls_psr;
    logic        w_cls_illegal;

    assign w_opcode   = ir_q[15:12];
    assign w_func     = ir_q[7:4];
    assign w_is_rform = (w_opcode == 4'h0);

    always_comb begin
        w_cls_write   = 1'b0;
        w_cls_psr     = 1'b0;
        w_cls_illegal = 1'b0;
        if (w_is_rform) begin
            // R-form: NOP touches nothing, the two compares only set flags,
            // every other function writes Rdest and flags.
            unique case (w_func)
                4'h0: begin
                    w_cls_write = 1'b0;
                    w_cls_psr   = 1'b0;
                end
                4'hB, 4'hD: begin
                    w_cls_write = 1'b0;
                    w_cls_psr   = 1'b1;
                end
                default: begin
                    w_cls_write = 1'b1;
                    w_cls_psr   = 1'b1;
                end
            endcase
        end else begin
            // I-form: opcode selects write+flags, flags-only (compares),
            // or an undefined encoding.
            unique case (w_opcode)
                4'h1, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hE: begin
                    w_cls_write = 1'b1;
                    w_cls_psr   = 1'b1;
                end
                4'h2, 4'hB: begin
                    w_cls_psr   = 1'b1;
                end
                default: begin
                    w_cls_illegal = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // ALU control encoding
    //   R-form : the instruction word is the control word.
    //   I-form : {op, imm[7:4], 4'b0000, imm[3:0]}; undefined opcodes
    //            drive an all-zero control word so the ALU sees a NOP.
    // ------------------------------------------------------------------
    always_comb begin
        alu_control = 16'h0000;
        if (w_is_rform) begin
            alu_control = ir_q;
        end else if (!w_cls_illegal) begin
            alu_control = {w_opcode, ir_q[7:4], 4'b0000, ir_q[3:0]};
        end
    end

    // ------------------------------------------------------------------
    // Register-file / ALU operand wiring
    // ------------------------------------------------------------------
    assign rf_raddr_a = ir_q[11:8];
    assign rf_raddr_b = ir_q[3:0];
    assign alu_in1    = rf_rdata_a;
    assign alu_in2    = rf_rdata_b;

    // ------------------------------------------------------------------
    // Next-state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        res_d   = res_q;
        flg_d   = flg_q;
        waddr_d = waddr_q;
        psr_d   = psr_q;

        unique case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_EX;
            end
            S_EX: begin
                // Capture the result and its destination together so the
                // write port stays stable until the next instruction's WB,
                // even though the IR changes at the next accept.
                res_d   = alu_out;
                flg_d   = alu_flags;
                waddr_d = ir_q[11:8];
                state_d = S_WB;
            end
            S_WB: begin
                if (w_cls_psr) begin
                    psr_d = flg_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            waddr_q <= '0;
            psr_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            waddr_q <= waddr_d;
            psr_q   <= psr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes are decodes of the registered state, so they are
    // exactly one cycle wide and forced low by reset.
    // ------------------------------------------------------------------
    assign instr_ready = (state_q == S_IDLE);
    assign done        = (state_q == S_WB);
    assign illegal     = (state_q == S_WB) && w_cls_illegal;
    assign rf_we       = (state_q == S_WB) && w_cls_write;
    assign rf_waddr    = waddr_q;
    assign rf_wdata    = res_q;
    assign psr         = psr_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_ctrl
//  Description : Self-checking bench for alu_issue_ctrl with a synchronous
//                register-file model, a simple ALU model and an
//                instruction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  rf_raddr_a, rf_raddr_b;
    logic [15:0] rf_rdata_a, rf_rdata_b;
    logic [15:0] alu_in1, alu_in2, alu_control, alu_out;
    logic [4:0]  alu_flags;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [4:0]  psr;
    logic        done, illegal;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;

    // bench-side register file (synchronous read, write-after-read)
    logic [15:0] rf [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    // reference state
    logic [15:0] model_rf [16];
    logic [4:0]  model_psr;

    // ALU flag override for directed cases
    logic        ovr_en = 1'b0;
    logic [4:0]  ovr_flags = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rf_rdata_a <= rf[rf_raddr_a];
        rf_rdata_b <= rf[rf_raddr_b];
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    function automatic logic [15:0] alu_fn_out(logic [15:0] a, logic [15:0] b, logic [15:0] c);
        return (a + b) ^ {c[15:12], 12'h000};
    endfunction

    function automatic logic [4:0] alu_fn_flags(logic [15:0] a, logic [15:0] b, logic [15:0] c);
        logic [16:0] s;
        logic [15:0] o;
        s = {1'b0, a} + {1'b0, b};
        o = alu_fn_out(a, b, c);
        return {o == 16'h0, s[16], a[15] ^ o[15], o[15], a < b};
    endfunction

    always_comb begin
        alu_out   = alu_fn_out(alu_in1, alu_in2, alu_control);
        alu_flags = ovr_en ? ovr_flags : alu_fn_flags(alu_in1, alu_in2, alu_control);
    end

    alu_issue_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_rdata_a  (rf_rdata_a),
        .rf_rdata_b  (rf_rdata_b),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_control (alu_control),
        .alu_out     (alu_out),
        .alu_flags   (alu_flags),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .psr         (psr),
        .done        (done),
        .illegal     (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---- instruction-level reference rules ----
    function automatic bit is_illegal(logic [15:0] i);
        return (i[15:12] inside {4'h4, 4'h8, 4'hA, 4'hC, 4'hD, 4'hF});
    endfunction

    function automatic bit writes(logic [15:0] i);
        if (i[15:12] == 4'h0) return !(i[7:4] inside {4'h0, 4'hB, 4'hD});
        return (i[15:12] inside {4'h1, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hE});
    endfunction

    function automatic bit sets_psr(logic [15:0] i);
        if (i[15:12] == 4'h0) return (i[7:4] != 4'h0);
        return (i[15:12] inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'hE});
    endfunction

    function automatic logic [15:0] exp_ctrl(logic [15:0] i);
        if (i[15:12] == 4'h0) return i;
        if (is_illegal(i)) return 16'h0000;
        return {i[15:12], i[7:4], 4'h0, i[3:0]};
    endfunction

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        model_rf[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one instruction starting from an IDLE negedge; returns at the
    // negedge after WB (back in IDLE). hold keeps instr_valid asserted so
    // the next call's instruction is taken at the earliest opportunity.
    task automatic issue(input logic [15:0] ins, input bit hold, input bit gapchk);
        logic [3:0]  rd, rs;
        logic [15:0] a, b, ctrl, res;
        logic [4:0]  fl;
        rd   = ins[11:8];
        rs   = ins[3:0];
        a    = model_rf[rd];
        b    = model_rf[rs];
        ctrl = exp_ctrl(ins);
        res  = alu_fn_out(a, b, ctrl);
        fl   = ovr_en ? ovr_flags : alu_fn_flags(a, b, ctrl);

        chk("idle_ready", instr_ready, 1);
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk);
        if (gapchk) chk("accept_gap", cyc - last_acc, 4);
        last_acc = cyc;
        @(negedge clk);
        if (!hold) instr_valid = 1'b0;
        chk("rd_ready", instr_ready, 0);
        chk("raddr_a", rf_raddr_a, rd);
        chk("raddr_b", rf_raddr_b, rs);
        @(negedge clk);
        chk("ex_ctrl", alu_control, ctrl);
        chk("ex_in1", alu_in1, a);
        chk("ex_in2", alu_in2, b);
        chk("ex_done", done, 0);
        @(negedge clk);
        chk("wb_we", rf_we, writes(ins));
        chk("wb_done", done, 1);
        chk("wb_illegal", illegal, is_illegal(ins));
        if (writes(ins)) begin
            chk("wb_waddr", rf_waddr, rd);
            chk("wb_wdata", rf_wdata, res);
            model_rf[rd] = res;
        end
        if (sets_psr(ins)) model_psr = fl;
        @(negedge clk);
        chk("psr", psr, model_psr);
        chk("post_done", done, 0);
        chk("post_we", rf_we, 0);
    endtask

    initial begin
        logic [15:0] r;
        bit          h, prev_h;
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        model_psr   = 5'b00000;
        for (int i = 0; i < 16; i++) begin
            r = 16'($urandom);
            preload(4'(i), r);
        end
        preload(4'd2, 16'd3);
        preload(4'd1, 16'd4);

        // reset state
        chk("rst_psr", psr, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_ready", instr_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // reset in the middle of EX of an ADD: instruction discarded
        r = model_rf[5];
        instr_valid = 1'b1;
        instr       = 16'h0516;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_we", rf_we, 0);
        chk("midrst_psr", psr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", instr_ready, 1);
        chk("midrst_psr2", psr, 0);
        chk("midrst_rf", rf[5], r);

        // ADD r2,r1 with flags forced to zero
        ovr_en = 1'b1; ovr_flags = 5'b00000;
        issue(16'h0251, 1'b0, 1'b0);
        chk("add_rf", rf[2], 16'h0007);
        ovr_en = 1'b0;

        // ADDI r3,0xA5
        issue(16'h53A5, 1'b0, 1'b0);

        // CMP r4,r1: flags only
        ovr_en = 1'b1; ovr_flags = 5'b00011;
        issue(16'h04B1, 1'b0, 1'b0);
        ovr_en = 1'b0;
        chk("cmp_psr", psr, 5'b00011);

        // undefined I-form opcode
        issue(16'h4123, 1'b0, 1'b0);
        chk("ill_psr", psr, 5'b00011);

        // held valid: back-to-back ADDs, then NOP
        issue(16'h0615, 1'b1, 1'b0);
        issue(16'h0716, 1'b0, 1'b1);
        issue(16'h0000, 1'b0, 1'b0);

        // randomized instruction stream
        prev_h = 1'b0;
        for (int n = 0; n < 60; n++) begin
            r = 16'($urandom);
            h = 1'($urandom_range(0, 1));
            issue(r, h, prev_h);
            prev_h = h;
        end
        instr_valid = 1'b0;

        for (int i = 0; i < 16; i++) begin
            chk("final_rf", rf[i], model_rf[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
